instr_fetch_unit: RTL and testbench

- Upstream neighbour of the main-decoder control unit in the single-cycle MIPS32 datapath.
- Owns the PC register, the instruction memory and the run/halt sequencing.
- Presents instr[31:26] to the decoder and consumes the decoder's branch/jump/halt outputs plus the ALU zero flag to select the next PC.
- Provides a program-load port and performance counters for bench/bootloader use.

---
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, instruction memory, run/halt sequencing
// and performance counters for the single-cycle MIPS32 datapath.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          branch,
  input  logic                          jump,
  input  logic                          halt,
  input  logic                          alu_zero,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_plus4,
  output logic [31:0]                   instr,
  output logic                          instr_valid,
  output logic                          halted,
  output logic [31:0]                   cycle_count,
  output logic [31:0]                   instr_count
);

  localparam int unsigned AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC0     = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] HALT_OP = 32'hFC00_0000;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] br_off;
  logic        clr_cnt;
  logic        in_range;
  logic [31:0] imem [IMEM_DEPTH];

  assign pc_plus4    = pc + 32'd4;
  assign instr_valid = (state == RUN);
  assign halted      = (state == HALTED);
  assign in_range    = (pc[31:AW+2] == '0);
  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Fetches beyond the memory return the halt opcode so the decoder stops the machine.
  always_comb begin
    instr = '0;
    if (state == RUN)
      instr = in_range ? imem[pc[AW+1:2]] : HALT_OP;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    clr_cnt = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      HALTED: begin
        if (start) begin
          state_n = RUN;
          pc_n    = PC0;
          clr_cnt = 1'b1;
        end
      end
      RUN: begin
        if (halt)                   state_n = HALTED;
        else if (jump)              pc_n = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && alu_zero) pc_n = pc_plus4 + br_off;
        else                        pc_n = pc_plus4;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (clr_cnt) begin
        cycle_count <= '0;
        instr_count <= '0;
      end else if (state == RUN) begin
        if (cycle_count != '1)          cycle_count <= cycle_count + 32'd1;
        if (!halt && instr_count != '1) instr_count <= instr_count + 32'd1;
      end
    end
  end

  // Memory has no reset so a loaded program survives a mid-run abort.
  always_ff @(posedge clk) begin
    if (prog_we && state != RUN)
      imem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected outputs are queued per step
// and popped/compared one clock after the stimulus is applied.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, branch, jump, halt, alu_zero, prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc, pc_plus4, instr, cycle_count, instr_count;
  logic        instr_valid, halted;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          ci;
    bit          v;
    bit          h;
    logic [31:0] c;
    logic [31:0] i;
  } exp_t;

  exp_t sbq[$];

  localparam logic [31:0] ADDI1 = 32'h2001_0001;
  localparam logic [31:0] ADDI2 = 32'h2002_0002;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] HLT   = 32'hFC00_0000;
  localparam logic [31:0] BEQ   = 32'h1000_FFFE;
  localparam logic [31:0] J100  = 32'h0800_0040;
  localparam logic [31:0] J40   = 32'h0800_0010;
  localparam logic [31:0] J400  = 32'h0800_0100;

  instr_fetch_unit #(.IMEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .branch(branch), .jump(jump),
    .halt(halt), .alu_zero(alu_zero), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc),
    .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic compare_out();
    exp_t e;
    e = sbq.pop_front();
    vectors++;
    assert (pc === e.pc) else begin
      miscompares++; $error("FAIL %s pc got %h expected %h", e.tag, pc, e.pc);
    end
    vectors++;
    assert (pc_plus4 === e.pc + 32'd4) else begin
      miscompares++; $error("FAIL %s pc_plus4 got %h expected %h", e.tag, pc_plus4, e.pc + 32'd4);
    end
    if (e.ci) begin
      vectors++;
      assert (instr === e.instr) else begin
        miscompares++; $error("FAIL %s instr got %h expected %h", e.tag, instr, e.instr);
      end
    end
    vectors++;
    assert (instr_valid === e.v) else begin
      miscompares++; $error("FAIL %s instr_valid got %b expected %b", e.tag, instr_valid, e.v);
    end
    vectors++;
    assert (halted === e.h) else begin
      miscompares++; $error("FAIL %s halted got %b expected %b", e.tag, halted, e.h);
    end
    vectors++;
    assert (cycle_count === e.c) else begin
      miscompares++; $error("FAIL %s cycle_count got %0d expected %0d", e.tag, cycle_count, e.c);
    end
    vectors++;
    assert (instr_count === e.i) else begin
      miscompares++; $error("FAIL %s instr_count got %0d expected %0d", e.tag, instr_count, e.i);
    end
  endtask

  // Queue the expectation for the current stimulus, clock once, then check.
  task automatic step(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                      input bit ci, input bit ev, input bit eh,
                      input logic [31:0] ec, input logic [31:0] ei);
    exp_t e;
    e.tag = tag; e.pc = epc; e.instr = ein; e.ci = ci;
    e.v = ev; e.h = eh; e.c = ec; e.i = ei;
    sbq.push_back(e);
    @(posedge clk); #1;
    compare_out();
    start = 0; branch = 0; jump = 0; halt = 0; alu_zero = 0; prog_we = 0; rst = 0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  initial begin
    rst = 1; start = 0; branch = 0; jump = 0; halt = 0; alu_zero = 0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
    @(posedge clk); #1;
    rst = 1;
    step("reset", 32'h0, 32'h0, 1, 0, 0, 0, 0);
    step("idle", 32'h0, 32'h0, 1, 0, 0, 0, 0);

    start = 1; step("start_noprog", 32'h0, 32'h0, 0, 1, 0, 0, 0);
    halt = 1;  step("halt0", 32'h0, 32'h0, 1, 0, 1, 1, 0);

    // Program 1: addi, addi, nop, halt; word 3 written on the start edge
    load(8'd0, ADDI1); load(8'd1, ADDI2); load(8'd2, NOP);
    prog_we = 1; prog_addr = 8'd3; prog_data = HLT; start = 1;
    step("p1_pc0", 32'h0, ADDI1, 1, 1, 0, 0, 0);
    step("p1_pc4", 32'h4, ADDI2, 1, 1, 0, 1, 1);
    step("p1_pc8", 32'h8, NOP, 1, 1, 0, 2, 2);
    prog_we = 1; prog_addr = 8'd1; prog_data = 32'hDEAD_BEEF;
    step("p1_pc12", 32'hC, HLT, 1, 1, 0, 3, 3);
    halt = 1;  step("p1_halt", 32'hC, 32'h0, 1, 0, 1, 4, 3);
    jump = 1; branch = 1; alu_zero = 1;
    step("halted_hold", 32'hC, 32'h0, 1, 0, 1, 4, 3);

    // Program 2: branch taken/not taken, jumps, out-of-range fetch
    load(8'd2, BEQ); load(8'd3, NOP); load(8'd4, J100);
    load(8'h40, J40); load(8'h10, J400);
    start = 1; step("p2_start", 32'h0, ADDI1, 1, 1, 0, 0, 0);
    start = 1; step("run_start_ign", 32'h4, ADDI2, 1, 1, 0, 1, 1);
    step("beq_at8", 32'h8, BEQ, 1, 1, 0, 2, 2);
    branch = 1; alu_zero = 1;
    step("beq_taken", 32'h4, ADDI2, 1, 1, 0, 3, 3);
    step("beq_again", 32'h8, BEQ, 1, 1, 0, 4, 4);
    branch = 1; alu_zero = 0;
    step("beq_nottaken", 32'hC, NOP, 1, 1, 0, 5, 5);
    step("seq_16", 32'h10, J100, 1, 1, 0, 6, 6);
    jump = 1;  step("jump_100", 32'h100, J40, 1, 1, 0, 7, 7);
    jump = 1; branch = 1; alu_zero = 1;
    step("jump_wins", 32'h40, J400, 1, 1, 0, 8, 8);
    jump = 1;  step("jump_oor", 32'h400, HLT, 1, 1, 0, 9, 9);
    halt = 1;  step("halt_oor", 32'h400, 32'h0, 1, 0, 1, 10, 9);

    // Restart from HALTED with a rewritten word 0, then abort with reset
    load(8'd0, 32'h1234_5678);
    start = 1; step("restart", 32'h0, 32'h1234_5678, 1, 1, 0, 0, 0);
    step("restart_pc4", 32'h4, ADDI2, 1, 1, 0, 1, 1);
    rst = 1;   step("rst_midrun", 32'h0, 32'h0, 1, 0, 0, 0, 0);
    start = 1; step("mem_kept", 32'h0, 32'h1234_5678, 1, 1, 0, 0, 0);
    halt = 1;  step("final_halt", 32'h0, 32'h0, 1, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
